// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
// Module      : display_scan
// Description : Four-digit 7-segment scan driver. Latches a frame of BCD
//               digits at each frame start, multiplexes them onto a shared
//               active-low segment bus, and generates the blink phase.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 32
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] blink_en,
    input  logic       blank_lz,
    input  logic       disp_en,
    output logic [6:0] display_out,
    output logic [3:0] segment_digit,
    output logic       dblink
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] C_SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] C_BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] C_SCAN_ONE   = SW'(1);
    localparam logic [BW-1:0] C_BLINK_ONE  = BW'(1);
    localparam logic [6:0]    C_SEG_OFF    = 7'b1111111;
    localparam logic [3:0]    C_AN_OFF     = 4'b1111;

    logic [SW-1:0]      scan_cnt_q,  scan_cnt_d;
    logic [1:0]         idx_q,       idx_d;
    logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
    logic               dblink_q,    dblink_d;
    logic [3:0][3:0]    shadow_q,    shadow_d;
    logic [3:0]         blink_prev_q, blink_prev_d;
    logic [6:0]         display_q,   display_d;
    logic [3:0]         anode_q,     anode_d;

    logic               w_scan_wrap;
    logic               w_frame_start;
    logic               w_blink_wrap;
    logic               w_blink_restart;
    logic [3:0]         w_val;
    logic               w_dark;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD values show a dash.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b0111111;
        endcase
    endfunction

    // Next-state for scan/blink counters and shadows, plus output decode from post-edge state.
    always_comb begin
        scan_cnt_d   = scan_cnt_q;
        idx_d        = idx_q;
        blink_cnt_d  = blink_cnt_q;
        dblink_d     = dblink_q;
        shadow_d     = shadow_q;
        blink_prev_d = blink_en;

        w_scan_wrap     = (scan_cnt_q == C_SCAN_LAST);
        w_frame_start   = w_scan_wrap && (idx_q == 2'd3);
        w_blink_wrap    = (blink_cnt_q == C_BLINK_LAST);
        w_blink_restart = (blink_prev_q == 4'b0000) && (blink_en != 4'b0000);

        if (w_scan_wrap) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + C_SCAN_ONE;
        end

        if (w_frame_start) begin
            shadow_d = {d3, d2, d1, d0};
        end

        // Restart wins over wrap so a newly selected digit is visible first.
        if (w_blink_restart) begin
            blink_cnt_d = '0;
            dblink_d    = 1'b0;
        end else if (w_blink_wrap) begin
            blink_cnt_d = '0;
            dblink_d    = ~dblink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + C_BLINK_ONE;
        end

        w_val  = shadow_d[idx_d];
        w_dark = !disp_en
              || (blink_en[idx_d] && dblink_d)
              || ((idx_d == 2'd3) && blank_lz && (w_val == 4'd0));

        if (w_dark) begin
            anode_d   = C_AN_OFF;
            display_d = C_SEG_OFF;
        end else begin
            anode_d   = ~(4'b0001 << idx_d);
            display_d = seg7(w_val);
        end
    end

    // State and registered outputs; reset parks the scan so the first edge starts a frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            scan_cnt_q   <= C_SCAN_LAST;
            idx_q        <= 2'd3;
            blink_cnt_q  <= '0;
            dblink_q     <= 1'b0;
            shadow_q     <= '0;
            blink_prev_q <= 4'b0000;
            display_q    <= C_SEG_OFF;
            anode_q      <= C_AN_OFF;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            dblink_q     <= dblink_d;
            shadow_q     <= shadow_d;
            blink_prev_q <= blink_prev_d;
            display_q    <= display_d;
            anode_q      <= anode_d;
        end
    end

    assign display_out   = display_q;
    assign segment_digit = anode_q;
    assign dblink        = dblink_q;

endmodule
`default_nettype wire
